// File: rtl/and_gates_pkg.sv
// Shared types and constants for the AND-gate arbiter slice.
// Optional build macro: AND_ARB_STATS_EN (see and_gate_rr_arbiter).
package and_gates_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam int AND_ARB_MAX_REQ = 16;
  localparam int OP_CNT_W        = 16;

  // Increment modulo n without a divider.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/and_gate_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr,
// searching upward and wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  int j;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) idx = ID_W'(j);
    end
  end

endmodule

// File: rtl/and_gate_rr_arbiter.sv
// N_REQ requesters share one registered W-bit AND unit through a round-robin arbiter.
// Define AND_ARB_STATS_EN to add the saturating op_count output.
module and_gate_rr_arbiter
  import and_gates_pkg::*;
#(
  parameter int  N_REQ = 4,
  parameter int  W     = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       y_out,
  output logic               y_valid,
  output logic [ID_W-1:0]    y_id,
  output logic               busy
`ifdef AND_ARB_STATS_EN
  ,
  output logic [OP_CNT_W-1:0] op_count
`endif
);

  localparam logic [N_REQ-1:0] GNT_LSB = N_REQ'(1);

  state_t          state;
  state_t          state_nxt;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] rr_ptr;
  logic            take;
  logic [ID_W-1:0] win_id_p0;
  logic [W-1:0]    op_a_p0;
  logic [W-1:0]    op_b_p0;

  rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign take = (state == IDLE) && pick_any;
  assign busy = (state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture the winner's operands at the grant edge.
  always_ff @(posedge clk) begin
    if (take) begin
      op_a_p0   <= a_in[int'(pick_idx)*W +: W];
      op_b_p0   <= b_in[int'(pick_idx)*W +: W];
      win_id_p0 <= pick_idx;
    end
  end

  // Stage p1: result, strobe and pointer advance one edge after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      y_id    <= '0;
      rr_ptr  <= '0;
    end else begin
      gnt     <= '0;
      y_valid <= 1'b0;
      if (take) gnt <= GNT_LSB << pick_idx;
      if (state == EXEC) begin
        y_out   <= op_a_p0 & op_b_p0;
        y_valid <= 1'b1;
        y_id    <= win_id_p0;
        rr_ptr  <= ID_W'(wrap_inc(int'(win_id_p0), N_REQ));
      end
    end
  end

`ifdef AND_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 op_count <= '0;
    else if (state == EXEC && op_count != '1)   op_count <= op_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_and_gate_rr_arbiter.sv
// Bench for and_gate_rr_arbiter: transaction-level model compared every cycle plus
// hand-computed directed expectations.
module tb_and_gate_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int ID_W  = 2;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_REQ-1:0]   req   = '0;
  logic [N_REQ*W-1:0] a_in  = '0;
  logic [N_REQ*W-1:0] b_in  = '0;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       y_out;
  logic               y_valid;
  logic [ID_W-1:0]    y_id;
  logic               busy;
`ifdef AND_ARB_STATS_EN
  logic [15:0]        op_count;
`endif

  int checks = 0;
  int errors = 0;

  and_gate_rr_arbiter #(
    .N_REQ(N_REQ),
    .W    (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .y_out  (y_out),
    .y_valid(y_valid),
    .y_id   (y_id),
    .busy   (busy)
`ifdef AND_ARB_STATS_EN
    ,
    .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request occupies the unit for one extra cycle,
  // then the result appears and the pointer moves past the winner.
  logic [N_REQ-1:0] m_gnt  = '0;
  logic             m_yv   = 1'b0;
  logic [W-1:0]     m_yout = '0;
  int               m_yid  = 0;
  int               m_ptr  = 0;
  logic             m_exec = 1'b0;
  logic [W-1:0]     m_a    = '0;
  logic [W-1:0]     m_b    = '0;
  int               m_win  = 0;
  int               m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    int w;
    int j;
    w = -1;
    j = 0;
    if (!rst_n) begin
      m_gnt <= '0; m_yv <= 1'b0; m_yout <= '0; m_yid <= 0;
      m_ptr <= 0;  m_exec <= 1'b0; m_cnt <= 0;
    end else if (m_exec) begin
      m_yv   <= 1'b1;
      m_yout <= m_a & m_b;
      m_yid  <= m_win;
      m_ptr  <= (m_win + 1) % N_REQ;
      m_gnt  <= '0;
      m_exec <= 1'b0;
      if (m_cnt < 65535) m_cnt <= m_cnt + 1;
    end else begin
      m_yv  <= 1'b0;
      m_gnt <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        j = (m_ptr + k) % N_REQ;
        if (w < 0 && req[j]) w = j;
      end
      if (w >= 0) begin
        m_gnt  <= N_REQ'(1) << w;
        m_a    <= a_in[w*W +: W];
        m_b    <= b_in[w*W +: W];
        m_win  <= w;
        m_exec <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_gnt", 32'(gnt), 32'(m_gnt));
    check("cyc_y_valid", 32'(y_valid), 32'(m_yv));
    check("cyc_busy", 32'(busy), 32'(m_exec));
    check("cyc_y_out", 32'(y_out), 32'(m_yout));
    check("cyc_y_id", 32'(y_id), m_yid);
`ifdef AND_ARB_STATS_EN
    check("cyc_op_count", 32'(op_count), m_cnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    for (int i = 0; i < N_REQ; i++) begin
      a_in[i*W +: W] = W'($urandom_range(0, 255));
      b_in[i*W +: W] = W'($urandom_range(0, 255));
    end
    a0 = a_in[0 +: W];
    b0 = b_in[0 +: W];

    // Reset held with every requester asking.
    req = 4'hF;
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_y_out", 32'(y_out), 0);
    check("rst_y_id", 32'(y_id), 0);
    rst_n = 1'b1;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_busy", 32'(busy), 1);
    req = 4'h0;
    tick();
    check("first_y_valid", 32'(y_valid), 1);
    check("first_y_id", 32'(y_id), 0);
    check("first_y_out", 32'(y_out), 32'(a0 & b0));
    check("first_gnt_low", 32'(gnt), 0);
    tick();

    // Single op from requester 2.
    a_in[2*W +: W] = 8'hF0;
    b_in[2*W +: W] = 8'h3C;
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'b0100);
    req = 4'h0;
    tick();
    check("single_y_valid", 32'(y_valid), 1);
    check("single_y_out", 32'(y_out), 32'h30);
    check("single_y_id", 32'(y_id), 2);
    check("single_gnt_low", 32'(gnt), 0);
    tick();
    check("hold_y_valid", 32'(y_valid), 0);
    check("hold_y_out", 32'(y_out), 32'h30);

    // Pointer now 3: requester 3 first, then wrap to 0.
    req = 4'b1001;
    tick();
    check("wrap_gnt3", 32'(gnt), 32'b1000);
    req = 4'b0001;
    tick();
    check("wrap_y_id3", 32'(y_id), 3);
    tick();
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    req = 4'h0;
    tick();
    check("wrap_y_id0", 32'(y_id), 0);
    tick();

    // One requester holding req is re-granted every second cycle.
    req = 4'b1000;
    tick();
    check("hold_req_gnt_a", 32'(gnt), 32'b1000);
    tick();
    check("hold_req_gap", 32'(gnt), 0);
    tick();
    check("hold_req_gnt_b", 32'(gnt), 32'b1000);
    req = 4'h0;
    tick();
    tick();

    // Reset during the EXEC cycle drops the op.
    req = 4'b0010;
    tick();
    check("midrst_gnt", 32'(gnt), 32'b0010);
    check("midrst_busy_pre", 32'(busy), 1);
    req = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_gnt_low", 32'(gnt), 0);
    tick();
    check("midrst_no_valid", 32'(y_valid), 0);
    check("midrst_y_out", 32'(y_out), 0);
    tick();
    rst_n = 1'b1;

    // Fairness with all requesters re-raising after service; pointer restarts at 0.
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fair_gnt", 32'(gnt), 32'(N_REQ'(1) << order[i]));
      req = 4'hF & ~(N_REQ'(1) << order[i]);
      tick();
      check("fair_y_valid", 32'(y_valid), 1);
      check("fair_y_id", 32'(y_id), order[i]);
      req = 4'hF;
    end
    req = 4'h0;
    tick();
    tick();

    // Arbitrary request patterns and operands, checked by the cycle model.
    for (int i = 0; i < 40; i++) begin
      req = N_REQ'($urandom_range(0, 15));
      for (int r = 0; r < N_REQ; r++) begin
        a_in[r*W +: W] = W'($urandom_range(0, 255));
        b_in[r*W +: W] = W'($urandom_range(0, 255));
      end
      tick();
    end
    req = 4'h0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
